// File: rtl/cordic_pkg.sv
// Shared constants and state encoding for the CORDIC sin/cos core.
// All angles and vector components are signed Q2.30.
package cordic_pkg;

    localparam int unsigned ITER_DEFAULT = 24;

    localparam logic [31:0] K_INIT    = 32'h26DD_3B6A;
    localparam logic [31:0] ANGLE_MAX = 32'h6487_ED51;
    localparam logic [31:0] ANGLE_MIN = 32'h9B78_12AF;
    localparam logic [31:0] QNAN      = 32'h7FC0_0000;

    // atan(2^-i) in Q2.30, i = 0..30
    localparam logic [31:0] ATAN_TABLE [0:30] = '{
        32'h3243_F6A9, 32'h1DAC_6705, 32'h0FAD_BAFC, 32'h07F5_6EA6,
        32'h03FE_AB76, 32'h01FF_D55B, 32'h00FF_FAAA, 32'h007F_FF55,
        32'h003F_FFEA, 32'h001F_FFFD, 32'h000F_FFFF, 32'h0007_FFFF,
        32'h0003_FFFF, 32'h0001_FFFF, 32'h0000_FFFF, 32'h0000_7FFF,
        32'h0000_3FFF, 32'h0000_1FFF, 32'h0000_0FFF, 32'h0000_07FF,
        32'h0000_03FF, 32'h0000_01FF, 32'h0000_00FF, 32'h0000_007F,
        32'h0000_003F, 32'h0000_001F, 32'h0000_000F, 32'h0000_0008,
        32'h0000_0004, 32'h0000_0002, 32'h0000_0001
    };

    typedef enum logic [1:0] {IDLE, ROTATE, CONVERT, DONE} state_t;

endpackage

// File: rtl/fix2float_q30.sv
// Combinational signed Q2.30 to IEEE754 single conversion.
// Mantissa is truncated (round toward zero); zero maps to +0.0.
module fix2float_q30 (
    input  logic [31:0] value,
    output logic [31:0] result
);

    logic        sign;
    logic [31:0] mag;
    logic [31:0] norm;
    logic [4:0]  p;

    always_comb begin
        sign = value[31];
        mag  = sign ? (~value + 32'd1) : value;
        p    = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (mag[i]) p = i[4:0];
        end
        norm = mag << (5'd31 - p);
        // exponent = 127 + p - 30
        if (mag == '0) result = '0;
        else           result = {sign, 8'd97 + {3'b000, p}, norm[30:8]};
    end

endmodule

// File: rtl/cordic_sincos_f32.sv
// Iterative CORDIC rotation core: one micro-rotation per clock, then a
// single-cycle fixed-to-float conversion of x (cos) and y (sin).
module cordic_sincos_f32
    import cordic_pkg::*;
#(
    parameter int unsigned ITER = ITER_DEFAULT,
    parameter int unsigned W    = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [31:0]  angle,
    output logic         busy,
    output logic         done,
    output logic [31:0]  sin_out,
    output logic [31:0]  cos_out,
    output logic         range_err
);

    state_t               state;
    logic signed [W-1:0]  x, y, z;
    logic signed [W-1:0]  x_sh, y_sh, atan_i;
    logic [4:0]           iter;
    logic [31:0]          x_f, y_f;

    assign x_sh   = x >>> iter;
    assign y_sh   = y >>> iter;
    assign atan_i = ATAN_TABLE[iter];

    fix2float_q30 u_cos (.value(x), .result(x_f));
    fix2float_q30 u_sin (.value(y), .result(y_f));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            range_err <= 1'b0;
            sin_out   <= '0;
            cos_out   <= '0;
            x         <= '0;
            y         <= '0;
            z         <= '0;
            iter      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if ($signed(angle) > $signed(ANGLE_MAX) ||
                            $signed(angle) < $signed(ANGLE_MIN)) begin
                            sin_out   <= QNAN;
                            cos_out   <= QNAN;
                            range_err <= 1'b1;
                            done      <= 1'b1;
                            state     <= DONE;
                        end else begin
                            x         <= K_INIT;
                            y         <= '0;
                            z         <= angle;
                            iter      <= '0;
                            range_err <= 1'b0;
                            busy      <= 1'b1;
                            state     <= ROTATE;
                        end
                    end
                end
                ROTATE: begin
                    // rotate toward z = 0: positive residual turns counter-clockwise
                    if (!z[W-1]) begin
                        x <= x - y_sh;
                        y <= y + x_sh;
                        z <= z - atan_i;
                    end else begin
                        x <= x + y_sh;
                        y <= y - x_sh;
                        z <= z + atan_i;
                    end
                    iter <= iter + 5'd1;
                    if (iter == 5'(ITER - 1)) state <= CONVERT;
                end
                CONVERT: begin
                    sin_out <= y_f;
                    cos_out <= x_f;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    state   <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_sincos_f32.sv
// Scoreboard bench for cordic_sincos_f32: a real-arithmetic sin/cos model
// predicts each result; a monitor checks every done pulse against the queue.
module tb_cordic_sincos_f32;

    localparam int unsigned ITER = 24;
    localparam real PI  = 3.14159265358979323846;
    localparam real TOL = 1.0 / 2097152.0;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] angle;
    logic        busy, done, range_err;
    logic [31:0] sin_out, cos_out;

    always #5 clk = ~clk;

    cordic_sincos_f32 #(.ITER(ITER), .W(32)) dut (
        .clk(clk), .rst(rst), .start(start), .angle(angle),
        .busy(busy), .done(done), .sin_out(sin_out), .cos_out(cos_out),
        .range_err(range_err)
    );

    typedef struct {
        logic [31:0] ang;
        bit          err;
        int unsigned due;
    } exp_t;

    exp_t        sbq[$];
    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          n_done = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic real q30(input logic [31:0] a);
        return real'($signed(a)) / 1073741824.0;
    endfunction

    function automatic bit in_range(input logic [31:0] a);
        real r;
        r = q30(a);
        return (r <= PI / 2.0) && (r >= -PI / 2.0);
    endfunction

    function automatic real f2r(input logic [31:0] f);
        real m;
        int  e;
        if (f[30:23] == 8'd0) return 0.0;
        m = 1.0 + real'(f[22:0]) / 8388608.0;
        e = int'(f[30:23]) - 127;
        while (e > 0) begin m = m * 2.0; e--; end
        while (e < 0) begin m = m / 2.0; e++; end
        return f[31] ? -m : m;
    endfunction

    function automatic real fabs(input real v);
        return (v < 0.0) ? -v : v;
    endfunction

    task automatic chk(input string name, input bit ok, input string act, input string req);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: actual %s, required %s (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic monitor();
        exp_t e;
        real  ts, tc, gs, gc;
        forever begin
            @(negedge clk);
            if (!rst && done) begin
                n_done++;
                chk("sb_nonempty", sbq.size() != 0, "unexpected done", "pending entry");
                if (sbq.size() != 0) begin
                    e = sbq.pop_front();
                    chk("latency", cyc == e.due, $sformatf("%0d", cyc), $sformatf("%0d", e.due));
                    chk("busy_at_done", busy == 1'b0, $sformatf("%b", busy), "0");
                    chk("range_err", range_err == e.err, $sformatf("%b", range_err), $sformatf("%b", e.err));
                    if (e.err) begin
                        chk("sin_nan", sin_out == 32'h7FC0_0000, $sformatf("%h", sin_out), "7fc00000");
                        chk("cos_nan", cos_out == 32'h7FC0_0000, $sformatf("%h", cos_out), "7fc00000");
                    end else begin
                        ts = $sin(q30(e.ang));
                        tc = $cos(q30(e.ang));
                        gs = f2r(sin_out);
                        gc = f2r(cos_out);
                        chk("sin_value", fabs(gs - ts) <= TOL,
                            $sformatf("%h (%.9f)", sin_out, gs), $sformatf("%.9f for angle %h", ts, e.ang));
                        chk("cos_value", fabs(gc - tc) <= TOL,
                            $sformatf("%h (%.9f)", cos_out, gc), $sformatf("%.9f for angle %h", tc, e.ang));
                    end
                end
            end
        end
    endtask

    task automatic run_op(input logic [31:0] a, input bit poke_busy, input bit poke_done);
        int unsigned s;
        bit          err;
        bit          got;
        int          d0;
        d0 = n_done;
        @(negedge clk);
        angle = a;
        start = 1'b1;
        s     = cyc;
        err   = !in_range(a);
        sbq.push_back('{ang: a, err: err, due: s + (err ? 1 : ITER + 2)});
        got = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            start = 1'b0;
            angle = $urandom;
            if (done) begin
                got = 1'b1;
                break;
            end
            if (poke_busy && cyc == s + 5) begin
                chk("busy_mid_op", busy == 1'b1, $sformatf("%b", busy), "1");
                angle = 32'h1234_5678;
                start = 1'b1;
            end
        end
        chk("done_seen", got, "no done within 40 cycles", "done");
        if (!got) sbq.delete();
        if (poke_busy || poke_done) begin
            if (poke_done) begin
                angle = 32'h0800_0000;
                start = 1'b1;
            end
            @(negedge clk);
            start = 1'b0;
            repeat (30) @(negedge clk);
            chk("single_done", n_done == d0 + 1, $sformatf("%0d", n_done - d0), "1");
        end else begin
            @(negedge clk);
        end
    endtask

    initial begin
        logic [31:0] dir [9];
        int          d0;
        dir = '{32'h0000_0000, 32'h2182_A471, 32'hCDBC_0957, 32'h6487_ED51, 32'h6487_ED52,
                32'h9B78_12AF, 32'h9B78_12AE, 32'h8000_0000, 32'h7FFF_FFFF};
        rst   = 1'b1;
        start = 1'b0;
        angle = '0;
        fork
            monitor();
        join_none

        repeat (3) @(negedge clk);
        chk("rst_busy", busy == 1'b0, $sformatf("%b", busy), "0");
        chk("rst_done", done == 1'b0, $sformatf("%b", done), "0");
        chk("rst_range_err", range_err == 1'b0, $sformatf("%b", range_err), "0");
        chk("rst_sin", sin_out == 32'h0, $sformatf("%h", sin_out), "00000000");
        chk("rst_cos", cos_out == 32'h0, $sformatf("%h", cos_out), "00000000");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        foreach (dir[i]) run_op(dir[i], 1'b0, 1'b0);

        run_op(32'h1A00_0000, 1'b1, 1'b0);
        run_op(32'hE800_0000, 1'b0, 1'b1);

        // abort an in-flight operation with an asynchronous reset
        d0 = n_done;
        @(negedge clk);
        angle = 32'h2182_A471;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        chk("busy_before_abort", busy == 1'b1, $sformatf("%b", busy), "1");
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", busy == 1'b0, $sformatf("%b", busy), "0");
        chk("abort_done", done == 1'b0, $sformatf("%b", done), "0");
        chk("abort_sin", sin_out == 32'h0, $sformatf("%h", sin_out), "00000000");
        chk("abort_cos", cos_out == 32'h0, $sformatf("%h", cos_out), "00000000");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (35) @(negedge clk);
        chk("abort_no_done", n_done == d0, $sformatf("%0d", n_done - d0), "0");

        run_op(32'hCDBC_0957, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            if (i % 2 == 0) run_op($urandom, 1'b0, 1'b0);
            else            run_op(32'($signed($urandom_range(32'd3373259426, 32'd0)) - 32'sd1686629713), 1'b0, 1'b0);
        end

        repeat (3) @(negedge clk);
        chk("sb_drained", sbq.size() == 0, $sformatf("%0d", sbq.size()), "0");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cordic_sincos_f32.md
Name: cordic_sincos_f32

Overview:
- Iterative CORDIC rotation core for the Sin_Cos datapath.
- Takes a fixed-point angle and produces sin and cos as IEEE754 single-precision words.
- Sits directly upstream of the float divider: its registered outputs feed the divider's A and B inputs, so tan = sin/cos can be formed.
- One rotation step per clock, start/done handshake.

Parameters:
- ITER, 24, number of CORDIC micro-rotations (legal range 16..30).
- W, 32, internal x/y/z datapath width (signed Q2.30).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request pulse; sampled only in IDLE.
- angle  in  32  signed Q2.30 radians; legal range −π/2..+π/2 inclusive.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse; sin_out/cos_out are valid in that cycle.
- sin_out  out  32  IEEE754 single sin(angle); held until the next accepted start.
- cos_out  out  32  IEEE754 single cos(angle); held until the next accepted start.
- range_err  out  1  set with done when angle is out of range; cleared on the next accepted start.

Behaviour:
- Reset: state = IDLE; busy, done and range_err = 0; sin_out = cos_out = 32'h0000_0000; iteration counter = 0.
- Reset is asynchronous and aborts any operation in progress. No done is produced for an aborted operation.
- State IDLE, on start:
  - If angle > 32'h6487_ED51 (+π/2) or angle < 32'h9B78_12AF (−π/2): go to DONE.
    - sin_out = cos_out = 32'h7FC0_0000 (qNaN).
    - range_err = 1.
  - Otherwise: x = 32'h26DD_3B6A (K ≈ 0.6072529), y = 0, z = angle, i = 0. Go to ROTATE.
- State ROTATE, one step per cycle, i = 0..ITER−1:
  - d = ~z[W−1].
  - x ← x − (d ? y>>>i : −(y>>>i)).
  - y ← y + (d ? x>>>i : −(x>>>i)).
  - z ← z − (d ? atan_i : −atan_i).
  - Shifts are arithmetic. All updates use values from the previous cycle.
  - atan_i = atan(2^−i) in Q2.30, taken from the constant table.
  - After step ITER−1, go to CONVERT.
- State CONVERT, one cycle: each of x and y is converted fixed → float.
  - sign = msb; mag = |value|.
  - p = index of the leading one of mag.
  - exponent = 127 + p − 30.
  - mantissa = the 23 bits below the leading one, left-justified and truncated (round toward zero).
  - mag = 0 gives 32'h0000_0000.
  - Results are registered into sin_out (from y) and cos_out (from x). Go to DONE.
- State DONE, one cycle: done = 1, busy = 0. Next state is IDLE.
- Latency: accepted start to done = ITER + 2 cycles (26 at default). Throughput is one result per ITER + 3 cycles.
- start while busy or in DONE is ignored. start in the same cycle that done is high is ignored.
- Q2.30 holds magnitudes below 2.0; worst-case |x|, |y| ≈ 1.0, so no overflow in range.
- Accuracy at ITER = 24: absolute error ≤ 2^−21 versus the true sin/cos.
- Outputs are never combinational from inputs.

Decomposition:
- Shared package cordic_pkg holds:
  - ITER default;
  - the atan table atan(2^−i), i = 0..30, as 32-bit Q2.30 constants (atan_0 = 32'h3243_F6A9);
  - constant K = 32'h26DD_3B6A;
  - range limits 32'h6487_ED51 and 32'h9B78_12AF;
  - QNAN = 32'h7FC0_0000;
  - state enum {IDLE, ROTATE, CONVERT, DONE}.
- One sub-module, fix2float_q30: combinational signed Q2.30 → IEEE754 single converter (leading-one detect plus shift). Instantiated twice, for x and y.

Test Plan:
- Angle 32'h0000_0000 → done at cycle 26; cos_out within 2^−21 of 1.0 (≈ 32'h3F80_0000); |sin_out| < 2^−21; range_err = 0.
- Angle 32'h2182_A471 (π/6) → sin_out within 2^−21 of 0.5 (32'h3F00_0000); cos_out within 2^−21 of 32'h3F5D_B3D7.
- Angle 32'hCDBC_0957 (−π/4) → sin_out ≈ 32'hBF35_04F3 and cos_out ≈ 32'h3F35_04F3, each within 2^−21.
- Angle 32'h6487_ED51 (+π/2, boundary) → accepted; sin_out ≈ 32'h3F80_0000 and |cos_out| < 2^−21. Angle 32'h6487_ED52 → done after 1 cycle; range_err = 1; both outputs 32'h7FC0_0000.
- Second start pulsed at cycle 5 of an operation → ignored; a single done at cycle 26 with the first operation's result; busy remains high throughout.
- rst asserted at cycle 10 of an operation → busy, done and outputs clear immediately; no done is produced. A new start after reset completes normally.
